// File: rtl/rv32i_types.sv
// Shared core types: M-extension funct3 encoding and the multiply/divide unit state.
package rv32i_types;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/m_ext_divider.sv
// Restoring divide-step datapath on unsigned magnitudes, one quotient bit per step.
module m_ext_divider
    import rv32i_types::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN+1:0] shifted, trial;

    // One guard bit above the remainder keeps the trial sign unambiguous.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {2'b00, divisor};
        if (trial[XLEN+1]) begin
            rem_d = shifted[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_d = trial[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    assign quo_next = quo_d;
    assign rem_next = rem_d[XLEN-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/m_ext_unit.sv
// RISC-V M-extension execute unit: iterative multiply/divide with divide early-outs.
// M_EXT_FAST_MUL_EN selects a single-cycle multiplier; divide stays iterative.
//
// state   | meaning
// MD_IDLE | ready; latch operands on accept
// MD_BUSY | shift-add / restoring iteration
// MD_DONE | result held until consumer handshake
module m_ext_unit
    import rv32i_types::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;

    md_state_t         state_q, state_d;
    m_funct3_t         op_in, op_q;
    logic              a_neg, b_neg, neg_in, neg_q, accept;
    logic [XLEN-1:0]   a_mag, b_mag, mcand_q, divisor_q;
    logic              early_hit, fast_hit, div_zero, div_ovf;
    logic [XLEN-1:0]   early_res, fast_res, iter_res;
    logic [2*XLEN-1:0] acc_q, acc_next, prod;
    logic [XLEN:0]     acc_sum;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   quo_next, rem_next, result_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign op_in  = m_funct3_t'(funct3);
    assign accept = (state_q == MD_IDLE) && in_valid && !flush;

    always_comb begin
        a_neg = rs1_val[XLEN-1] &&
                (op_in == M_MULH || op_in == M_MULHSU || op_in == M_DIV || op_in == M_REM);
        b_neg = rs2_val[XLEN-1] && (op_in == M_MULH || op_in == M_DIV || op_in == M_REM);
        a_mag = a_neg ? -rs1_val : rs1_val;
        b_mag = b_neg ? -rs2_val : rs2_val;
        case (op_in)
            M_MULH, M_MULHSU, M_DIV: neg_in = a_neg ^ b_neg;
            M_REM:                   neg_in = a_neg;
            default:                 neg_in = 1'b0;
        endcase
    end

    // op_in[1] separates the remainder ops from the quotient ops.
    always_comb begin
        div_zero  = op_in[2] && (rs2_val == '0);
        div_ovf   = (op_in == M_DIV || op_in == M_REM) &&
                    (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        early_hit = div_zero || div_ovf;
        if (div_zero)
            early_res = op_in[1] ? rs1_val : '1;
        else
            early_res = op_in[1] ? '0 : rs1_val;
    end

`ifdef M_EXT_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_raw, fast_prod;
    always_comb begin
        fast_raw  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_prod = neg_in ? -fast_raw : fast_raw;
        fast_hit  = !op_in[2];
        fast_res  = (op_in == M_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    always_comb begin
        acc_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_next = {acc_sum, acc_q[XLEN-1:1]};
        prod     = neg_q ? -acc_next : acc_next;
        case (op_q)
            M_MUL:                     iter_res = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: iter_res = prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             iter_res = neg_q ? -quo_next : quo_next;
            default:                   iter_res = neg_q ? -rem_next : rem_next;
        endcase
    end

    m_ext_divider #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state_q == MD_BUSY),
        .dividend (a_mag),
        .divisor  (divisor_q),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= MD_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = (early_hit || fast_hit) ? MD_DONE : MD_BUSY;
            MD_BUSY: if (flush) state_d = MD_IDLE;
                     else if (cnt_q == '0) state_d = MD_DONE;
            MD_DONE: if (flush || out_ready) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == MD_IDLE) && rst;
        busy      = (state_q != MD_IDLE);
        out_valid = (state_q == MD_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= M_MUL;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            divisor_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            neg_q     <= neg_in;
            mcand_q   <= a_mag;
            divisor_q <= b_mag;
            acc_q     <= {{XLEN{1'b0}}, b_mag};
            cnt_q     <= CW'(XLEN - 1);
            out_tag_q <= rd_tag;
            if (early_hit)
                result_q <= early_res;
            else if (fast_hit)
                result_q <= fast_res;
        end else if (state_q == MD_BUSY && !flush) begin
            acc_q <= acc_next;
            if (cnt_q == '0)
                result_q <= iter_res;
            else
                cnt_q <= cnt_q - CW'(1);
        end
    end

    assign result  = result_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Scoreboard bench for m_ext_unit: reference model, latency, hold, flush and reset checks.
module tb_m_ext_unit;

    localparam int XLEN = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       funct3 = '0;
    logic [XLEN-1:0]  rs1_val = '0;
    logic [XLEN-1:0]  rs2_val = '0;
    logic [TAG_W-1:0] rd_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    m_ext_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_tag(rd_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef M_EXT_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    // Returns after the accept edge (sampled #1 later).
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
        exp_t e;
        wait_ready();
        funct3 = f; rs1_val = a; rs2_val = b; rd_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = model(f, a, b);
        e.tag = t;
        e.lat = model_lat(f, a, b);
        sbq.push_back(e);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sbq.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("out_valid", 64'(out_valid), 1);
        chk("result", 64'(result), 64'(e.res));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_result", 64'(result), 64'(e.res));
            chk("hold_tag", 64'(out_tag), 64'(e.tag));
            chk("hold_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_ready", 64'(in_ready), 1);
        chk("post_hs_valid", 64'(out_valid), 0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
        send(f, a, b, t);
        collect(0);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_out_tag", 64'(out_tag), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 1);

        run_op(3'd0, 32'd7, 32'd6, 5'd1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd4);
        run_op(3'd4, -32'sd20, 32'd3, 5'd5);
        run_op(3'd6, -32'sd20, 32'd3, 5'd6);
        run_op(3'd5, 32'd20, 32'd3, 5'd7);
        run_op(3'd7, 32'd20, 32'd3, 5'd8);
        run_op(3'd5, 32'd20, 32'd0, 5'd9);
        run_op(3'd6, 32'd20, 32'd0, 5'd10);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 5'd14);

        for (int i = 0; i < 16; i++) begin
            rf = 3'(i % 8);
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op(rf, ra, rb, 5'(i + 16));
        end

        // DONE held with out_ready low
        send(3'd4, 32'd1000, -32'sd7, 5'd21);
        collect(5);

        // flush coincident with an accept: nothing taken
        wait_ready();
        funct3 = 3'd4; rs1_val = 32'd50; rs2_val = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_busy", 64'(busy), 0);
        chk("flush_acc_ready", 64'(in_ready), 1);

        // flush mid-divide at accept+10
        funct3 = 3'd4; rs1_val = -32'sd99; rs2_val = 32'd4; rd_tag = 5'd30; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("pre_flush_busy", 64'(busy), 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", 64'(in_ready), 1);
        chk("flush_busy", 64'(busy), 0);
        begin
            int seen = 0;
            repeat (XLEN + 4) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("flush_no_valid", 64'(seen), 0);
        end
        run_op(3'd0, 32'd3, 32'd3, 5'd17);

        // asynchronous reset mid-BUSY
        send(3'd5, 32'd12345, 32'd17, 5'd25);
        void'(sbq.pop_front());
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_result", 64'(result), 0);
        chk("mid_rst_tag", 64'(out_tag), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 1);
        run_op(3'd7, 32'd100, 32'd7, 5'd26);

        chk("sb_empty", 64'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
